mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle version of the MIPS core, replacing the single-cycle combinational control unit. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB over several clocks, so one shared memory and one ALU serve the whole instruction. It adds a memory ready handshake, a memory-timeout watchdog, a sticky fault/halt and a retired-instruction counter. It sits between the instruction register/zero flag and the datapath muxes and enables; the ALU function decoder stays separate and consumes alu_op.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles allowed in any memory state before fault; 0 disables the watchdog.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
opcode  in  6  instr[31:26] from the instruction register
zero  in  1  ALU zero flag (A==B)
mem_ready  in  1  shared memory has completed the current read or write this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load the instruction register
reg_dst  out  1  write register select: 0=rt, 1=rd
mem_to_reg  out  1  write data select: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0=PC, 1=A register
alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
alu_op  out  2  00=add, 01=sub, 10=decode funct
pc_src  out  2  next PC select: 00=ALU result, 01=ALUOut, 10=jump target
pc_en  out  1  PC load enable: PCWrite | (Branch & zero)
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
fault  out  1  sticky; the core is halted
fault_code  out  2  00=none, 01=illegal opcode, 10=memory timeout
retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Opcode decode: 000000 is R-type. 100011 is lw, 101011 is sw, 000100 is beq, 001000 is addi, 000010 is j. Any other opcode is illegal.
- Transitions:
  - FETCH goes to DECODE only when mem_ready=1; otherwise it holds.
  - DECODE goes to MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j), or HALT with fault_code=01 (illegal).
  - MEMADR goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD goes to MEMWB when mem_ready=1. MEMWRITE goes to FETCH when mem_ready=1. Both hold otherwise.
  - EXECUTE goes to ALUWB. ADDIEX goes to ADDIWB.
  - ALUWB, ADDIWB, MEMWB, BRANCH and JUMP go to FETCH.
  - HALT holds until reset.
- Outputs are decoded from state. Every field not listed below is 0.
  - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=mem_ready and PCWrite=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMREAD: iord=1, mem_read=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWRITE: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, Branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_dst=0, reg_write=1.
  - JUMP: pc_src=10, PCWrite=1.
- Latency with mem_ready=1 every cycle: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.
- instr_done=1 in ALUWB, ADDIWB, MEMWB, BRANCH and JUMP, and in MEMWRITE when mem_ready=1. retired increments on the same clock edge.
- Watchdog:
  - Counter clears on every state change and whenever mem_ready=1.
  - It increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - When it reaches MEM_TIMEOUT, the next state is HALT with fault_code=10.
- HALT: all enables 0, mem_read=0, fault=1, no further retires.
- Reset asserted, asynchronously:
  - state=FETCH, retired=0, watchdog=0, fault=0, fault_code=00.
  - While reset=0, every write strobe is gated off combinationally: mem_write, mem_read, ir_write, reg_write, pc_en.
  - Reset during MEMWRITE therefore drops mem_write in the same instant.
- Reset values of outputs (reset=0): all strobes 0, alu_src_b=01, all other fields 0, instr_done=0, fault=0, fault_code=00, retired=0.
- First FETCH strobes appear in the first cycle after reset is released.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state encoding;
  - the ALUOP_*, SRCB_* and PCSRC_* encodings;
  - the FAULT_* codes.
- No sub-module: one file with a next-state block, an output decode block, the watchdog and the counter.

Test Plan:
- lw, mem_ready=1 throughout → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. In cycle 5 reg_write=1 and mem_to_reg=1, instr_done pulses once, retired=1.
- beq with zero=1 → cycle 3 pc_en=1, pc_src=01, alu_op=01. Repeat with zero=0 → pc_en=0. retired=2 after both.
- mem_ready=0 for 3 cycles in FETCH, then 1 → state holds FETCH. ir_write=0 and pc_en=0 for 3 cycles, then both 1 for exactly one cycle.
- MEM_TIMEOUT=4, mem_ready held 0 in MEMREAD → after 4 wait cycles the state goes to HALT, fault=1, fault_code=10. Later mem_ready=1 has no effect.
- Opcode 111111 in DECODE → next cycle HALT, fault_code=01, no strobes, retired unchanged.
- reset=0 mid-MEMWRITE → mem_write=0 immediately, retired=0, fault cleared. After release the core restarts at FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Opcodes, FSM states, mux selects and fault codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic is_mem_wait(state_t s);
    return s inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory request/ready bus between control FSM and memory.
// The controller is master; memory answers with mem_ready.
interface mips_multicycle_ctrl_if;

  logic iord;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output iord,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  iord,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );

endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory watchdog,
// sticky fault/halt and retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  mips_multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             instr_done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  localparam int WD_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(MEM_TIMEOUT - 1);
  localparam bit WD_EN = (MEM_TIMEOUT > 0);

  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [WD_W-1:0]  wd_q;
  logic [CNT_W-1:0] retired_q;
  logic             timeout;

  logic iord_s, mrd_s, mwr_s, irw_s, rw_s;
  logic pcw_s, br_s, done_s;

  assign timeout = WD_EN && is_mem_wait(state_q)
                && !mem.mem_ready && (wd_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      S_FETCH:
        if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEMADR;
          (opcode == OP_RTYPE): state_d = S_EXECUTE;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_ADDI):  state_d = S_ADDIEX;
          (opcode == OP_J):     state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            code_d  = FAULT_ILLEGAL;
          end
        endcase
      S_MEMADR:
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE:
        if (mem.mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ALUWB, S_ADDIWB, S_MEMWB,
      S_BRANCH, S_JUMP: state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
    if (timeout) begin
      state_d = S_HALT;
      code_d  = FAULT_TIMEOUT;
    end
  end

  always_comb begin
    iord_s     = 1'b0;
    mrd_s      = 1'b0;
    mwr_s      = 1'b0;
    irw_s      = 1'b0;
    rw_s       = 1'b0;
    pcw_s      = 1'b0;
    br_s       = 1'b0;
    done_s     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    unique case (state_q)
      S_FETCH: begin
        mrd_s     = 1'b1;
        alu_src_b = SRCB_4;
        irw_s     = mem.mem_ready;
        pcw_s     = mem.mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        iord_s = 1'b1;
        mrd_s  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rw_s       = 1'b1;
        done_s     = 1'b1;
      end
      S_MEMWRITE: begin
        iord_s = 1'b1;
        mwr_s  = 1'b1;
        done_s = mem.mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        rw_s    = 1'b1;
        done_s  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        br_s      = 1'b1;
        done_s    = 1'b1;
      end
      S_ADDIWB: begin
        rw_s   = 1'b1;
        done_s = 1'b1;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pcw_s  = 1'b1;
        done_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so an async reset kills writes at once
  assign mem.iord      = iord_s;
  assign mem.mem_read  = mrd_s & reset;
  assign mem.mem_write = mwr_s & reset;
  assign ir_write      = irw_s & reset;
  assign reg_write     = rw_s & reset;
  assign pc_en         = (pcw_s | (br_s & zero)) & reset;
  assign instr_done    = done_s & reset;
  assign fault         = (state_q == S_HALT);
  assign fault_code    = code_q;
  assign retired       = retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      code_q    <= FAULT_NONE;
      wd_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (state_d != state_q || mem.mem_ready)
        wd_q <= '0;
      else if (is_mem_wait(state_q))
        wd_q <= wd_q + WD_W'(1);
      if (done_s)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl.
// Inputs change and outputs are sampled around the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        pc_en, instr_done, fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  mips_multicycle_ctrl_if mem();

  mips_multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .zero(zero),
    .mem(mem),
    .ir_write(ir_write),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_src(pc_src),
    .pc_en(pc_en),
    .instr_done(instr_done),
    .fault(fault),
    .fault_code(fault_code),
    .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t s);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    opcode = OP_LW;
    zero = 1'b0;
    mem.mem_ready = 1'b1;

    // reset values
    tick(); #1;
    check("rst_mrd", 32'(mem.mem_read), 0);
    check("rst_mwr", 32'(mem.mem_write), 0);
    check("rst_irw", 32'(ir_write), 0);
    check("rst_pcen", 32'(pc_en), 0);
    check("rst_srcb", 32'(alu_src_b), 32'(SRCB_4));
    check("rst_done", 32'(instr_done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_code", 32'(fault_code), 0);
    check("rst_ret", retired, 0);

    // lw with memory always ready
    tick(); reset = 1'b1; #1;
    chk_state("lw_c1", S_FETCH);
    check("lw_c1_mrd", 32'(mem.mem_read), 1);
    check("lw_c1_irw", 32'(ir_write), 1);
    check("lw_c1_pcen", 32'(pc_en), 1);
    tick(); #1;
    chk_state("lw_c2", S_DECODE);
    check("lw_c2_srcb", 32'(alu_src_b), 32'(SRCB_IMMSH));
    tick(); #1;
    chk_state("lw_c3", S_MEMADR);
    check("lw_c3_srcb", 32'(alu_src_b), 32'(SRCB_IMM));
    check("lw_c3_srca", 32'(alu_src_a), 1);
    tick(); #1;
    chk_state("lw_c4", S_MEMREAD);
    check("lw_c4_iord", 32'(mem.iord), 1);
    check("lw_c4_done", 32'(instr_done), 0);
    tick(); #1;
    chk_state("lw_c5", S_MEMWB);
    check("lw_c5_rw", 32'(reg_write), 1);
    check("lw_c5_m2r", 32'(mem_to_reg), 1);
    check("lw_c5_done", 32'(instr_done), 1);
    tick(); #1;
    chk_state("lw_end", S_FETCH);
    check("lw_end_done", 32'(instr_done), 0);
    check("lw_ret", retired, 1);

    // beq taken then not taken
    opcode = OP_BEQ;
    zero = 1'b1;
    tick(); #1;
    tick(); #1;
    chk_state("beq1_c3", S_BRANCH);
    check("beq1_pcen", 32'(pc_en), 1);
    check("beq1_pcsrc", 32'(pc_src), 32'(PCSRC_ALUOUT));
    check("beq1_aluop", 32'(alu_op), 32'(ALUOP_SUB));
    check("beq1_done", 32'(instr_done), 1);
    tick(); zero = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    chk_state("beq0_c3", S_BRANCH);
    check("beq0_pcen", 32'(pc_en), 0);
    tick(); #1;
    check("beq_ret", retired, 3);

    // fetch stall for three cycles, then R-type
    opcode = OP_RTYPE;
    mem.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_state("stall_st", S_FETCH);
      check("stall_irw", 32'(ir_write), 0);
      check("stall_pcen", 32'(pc_en), 0);
      tick(); #1;
    end
    mem.mem_ready = 1'b1; #1;
    check("unst_irw", 32'(ir_write), 1);
    check("unst_pcen", 32'(pc_en), 1);
    tick(); #1;
    chk_state("r_c2", S_DECODE);
    check("r_c2_irw", 32'(ir_write), 0);
    tick(); #1;
    chk_state("r_c3", S_EXECUTE);
    check("r_c3_aluop", 32'(alu_op), 32'(ALUOP_FUNCT));
    tick(); #1;
    chk_state("r_c4", S_ALUWB);
    check("r_c4_dst", 32'(reg_dst), 1);
    check("r_c4_rw", 32'(reg_write), 1);
    tick(); #1;
    check("r_ret", retired, 4);

    // sw completes normally
    opcode = OP_SW;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chk_state("sw_c4", S_MEMWRITE);
    check("sw_c4_mwr", 32'(mem.mem_write), 1);
    check("sw_c4_done", 32'(instr_done), 1);
    tick(); #1;
    chk_state("sw_end", S_FETCH);
    check("sw_ret", retired, 5);

    // sw interrupted by reset while writing
    tick(); #1;
    tick(); #1;
    tick(); mem.mem_ready = 1'b0; #1;
    check("swr_mwr", 32'(mem.mem_write), 1);
    check("swr_done", 32'(instr_done), 0);
    #1 reset = 1'b0; #1;
    check("swr_mwr_rst", 32'(mem.mem_write), 0);
    check("swr_ret_rst", retired, 0);
    chk_state("swr_st_rst", S_FETCH);
    tick(); reset = 1'b1; mem.mem_ready = 1'b1; #1;
    chk_state("swr_restart", S_FETCH);
    check("swr_restart_mrd", 32'(mem.mem_read), 1);

    // addi
    opcode = OP_ADDI;
    tick(); #1;
    tick(); #1;
    chk_state("addi_c3", S_ADDIEX);
    check("addi_c3_srcb", 32'(alu_src_b), 32'(SRCB_IMM));
    tick(); #1;
    chk_state("addi_c4", S_ADDIWB);
    check("addi_c4_rw", 32'(reg_write), 1);
    check("addi_c4_dst", 32'(reg_dst), 0);
    tick(); #1;
    check("addi_ret", retired, 1);

    // j
    opcode = OP_J;
    tick(); #1;
    tick(); #1;
    chk_state("j_c3", S_JUMP);
    check("j_c3_pcsrc", 32'(pc_src), 32'(PCSRC_JUMP));
    check("j_c3_pcen", 32'(pc_en), 1);
    tick(); #1;
    check("j_ret", retired, 2);

    // illegal opcode halts
    opcode = 6'b111111;
    tick(); #1;
    tick(); #1;
    chk_state("ill_st", S_HALT);
    check("ill_fault", 32'(fault), 1);
    check("ill_code", 32'(fault_code), 32'(FAULT_ILLEGAL));
    check("ill_mrd", 32'(mem.mem_read), 0);
    check("ill_pcen", 32'(pc_en), 0);
    tick(); #1;
    chk_state("ill_hold", S_HALT);
    check("ill_ret", retired, 2);

    // memory timeout in MEMREAD
    reset = 1'b0; #1;
    check("to_rst_fault", 32'(fault), 0);
    check("to_rst_code", 32'(fault_code), 0);
    tick(); reset = 1'b1; opcode = OP_LW; #1;
    tick(); #1;
    tick(); mem.mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk_state("to_wait", S_MEMREAD);
    end
    tick(); #1;
    chk_state("to_halt", S_HALT);
    check("to_fault", 32'(fault), 1);
    check("to_code", 32'(fault_code), 32'(FAULT_TIMEOUT));
    mem.mem_ready = 1'b1;
    tick(); #1;
    tick(); #1;
    chk_state("to_hold", S_HALT);
    check("to_mrd", 32'(mem.mem_read), 0);
    check("to_rw", 32'(reg_write), 0);
    check("to_ret", retired, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
